// File: rtl/golden_nonce_queue_pkg.sv
// Shared widths, FSM encoding and the nonce correction helper for the golden-nonce queue.
package golden_nonce_queue_pkg;

  localparam int NONCE_W = 32;
  localparam int OVF_W   = 8;
  localparam int GAP_W   = 16;

  typedef logic [NONCE_W-1:0] nonce_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Undo hashcore pipeline lag; wraps modulo 2^32.
  function automatic nonce_t correctNonce(input nonce_t raw, input nonce_t offset);
    return raw - offset;
  endfunction

endpackage

// File: rtl/golden_nonce_queue_if.sv
// Hashcore-to-jtag_comm signal bundle; master drives the rx side, slave (the queue) drives tx.
interface golden_nonce_queue_if import golden_nonce_queue_pkg::*; #(
  parameter int DEPTH = 8
) ();

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             rx_gn_match;
  nonce_t           rx_golden_nonce;
  logic             rx_new_work;
  logic             tx_new_nonce;
  nonce_t           tx_golden_nonce;
  logic [OVF_W-1:0] tx_overflow;
  logic [CNT_W-1:0] tx_count;

  modport master (
    output rx_gn_match, rx_golden_nonce, rx_new_work,
    input  tx_new_nonce, tx_golden_nonce, tx_overflow, tx_count
  );

  modport slave (
    input  rx_gn_match, rx_golden_nonce, rx_new_work,
    output tx_new_nonce, tx_golden_nonce, tx_overflow, tx_count
  );

endinterface

// File: rtl/golden_nonce_queue_nonce_fifo_ram.sv
// DEPTH x 32 distributed-RAM storage: synchronous write, asynchronous read, no reset on contents.
module nonce_fifo_ram import golden_nonce_queue_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  nonce_t                   wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output nonce_t                   rdata_o
);

  nonce_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/golden_nonce_queue.sv
// Queues golden-nonce hits and releases them to jtag_comm as single-cycle strobes
// separated by at least GAP_CYCLES idle cycles.
module golden_nonce_queue import golden_nonce_queue_pkg::*; #(
  parameter int     DEPTH        = 8,
  parameter nonce_t NONCE_OFFSET = '0,
  parameter int     GAP_CYCLES   = 16
) (
  input logic                 hash_clk,
  input logic                 reset,
  golden_nonce_queue_if.slave gnq
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  state_e           state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [OVF_W-1:0] ovf_q, ovf_d;
  nonce_t           held_q, held_d;

  logic   pushReq;
  logic   pushEn;
  logic   popEn;
  logic   full;
  logic   drop;
  nonce_t headNonce;

  assign popEn   = (state_q == ST_EMIT);
  assign full    = (count_q == CNT_W'(DEPTH));
  // A hit coinciding with new work belongs to the old job and is discarded.
  assign pushReq = gnq.rx_gn_match & ~gnq.rx_new_work;
  assign pushEn  = pushReq & (~full | popEn);
  assign drop    = pushReq & full & ~popEn;

  nonce_fifo_ram #(.DEPTH(DEPTH)) u_ram (
    .clk_i   (hash_clk),
    .we_i    (pushEn),
    .waddr_i (wptr_q),
    .wdata_i (correctNonce(gnq.rx_golden_nonce, NONCE_OFFSET)),
    .raddr_i (rptr_q),
    .rdata_o (headNonce)
  );

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    held_d  = held_q;

    unique case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        state_d = ST_GAP;
        gap_d   = GAP_W'(GAP_CYCLES);
      end
      ST_GAP: begin
        gap_d = gap_q - GAP_W'(1);
        if (gap_q == GAP_W'(1)) begin
          state_d = (count_q != '0) ? ST_EMIT : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (popEn) begin
      held_d = headNonce;
      rptr_d = rptr_q + AW'(1);
    end
    if (pushEn) begin
      wptr_d = wptr_q + AW'(1);
    end
    count_d = count_q + CNT_W'(pushEn) - CNT_W'(popEn);

    if (drop && (ovf_q != {OVF_W{1'b1}})) begin
      ovf_d = ovf_q + OVF_W'(1);
    end

    // Flush overrides queue bookkeeping; the strobe of a current EMIT still goes out.
    if (gnq.rx_new_work) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      state_d = ST_GAP;
      gap_d   = GAP_W'(GAP_CYCLES);
    end
  end

  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= '0;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      held_q  <= held_d;
    end
  end

  assign gnq.tx_new_nonce    = popEn;
  assign gnq.tx_golden_nonce = popEn ? headNonce : held_q;
  assign gnq.tx_overflow     = ovf_q;
  assign gnq.tx_count        = count_q;

endmodule
